// File: rtl/risc16b_io.sv
// risc16b_io: memory-mapped I/O block (LED register, 32-bit cycle counter, UART transmitter).
// The UART FIFO and TX state machine are built only when RISC16B_IO_UART_EN is defined.
module risc16b_io #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_addr,
    input  logic        d_oe,
    input  logic [15:0] d_dout,
    input  logic [1:0]  d_we,
    output logic        io_sel,
    output logic [15:0] io_din,
    output logic [15:0] led,
    output logic        uart_tx
);
    localparam int unsigned IDX_W = 7;
    localparam logic [IDX_W-1:0] IDX_LED    = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_CNT_LO = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_CNT_HI = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_UART   = IDX_W'(3);

    logic [IDX_W-1:0] idx;
    logic [31:0]      cnt;
    logic [15:0]      cnt_shadow;
    logic [15:0]      uart_status;
    logic             addr_lsb_unused;

    assign io_sel          = (d_addr[15:8] == 8'h7f);
    assign idx             = d_addr[7:1];
    assign addr_lsb_unused = d_addr[0];

    // LED register: d_we[0] owns the high byte, d_we[1] the low byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led <= '0;
        end else if (io_sel && (idx == IDX_LED)) begin
            if (d_we[0]) led[15:8] <= d_dout[15:8];
            if (d_we[1]) led[7:0]  <= d_dout[7:0];
        end
    end

    // Free-running cycle counter; a CNT_LO write clears it ahead of the increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (io_sel && (idx == IDX_CNT_LO) && (d_we != 2'b00)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

    // Reading the low half snapshots the high half so a 32-bit read is coherent
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_shadow <= '0;
        end else if (io_sel && d_oe && (idx == IDX_CNT_LO)) begin
            cnt_shadow <= cnt[31:16];
        end
    end

    always_comb begin
        io_din = '0;
        if (io_sel && d_oe) begin
            case (idx)
                IDX_LED:    io_din = led;
                IDX_CNT_LO: io_din = cnt[15:0];
                IDX_CNT_HI: io_din = cnt_shadow;
                IDX_UART:   io_din = uart_status;
                default:    io_din = '0;
            endcase
        end
    end

`ifdef RISC16B_IO_UART_EN
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = 16;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_push;
    logic              fifo_wr;
    logic              fifo_pop;
    logic              baud_done;
    tx_state_t         state;
    tx_state_t         state_nxt;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BAUD_W-1:0] baud_nxt;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_nxt;
    logic [7:0]        tx_byte;
    logic              tx_nxt;

    assign fifo_push   = io_sel && (idx == IDX_UART) && d_we[1];
    assign fifo_empty  = (fifo_cnt == '0);
    assign fifo_full   = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    // A full FIFO still accepts a push when the head is leaving on the same edge
    assign fifo_wr     = fifo_push && (!fifo_full || fifo_pop);
    assign baud_done   = (baud_cnt == BAUD_LAST);
    assign uart_status = {14'b0, fifo_full, (!fifo_empty || (state != ST_IDLE))};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_wr)  wr_ptr <= wr_ptr + PTR_W'(1);
            if (fifo_pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (fifo_wr && !fifo_pop)      fifo_cnt <= fifo_cnt + CNT_W'(1);
            else if (!fifo_wr && fifo_pop) fifo_cnt <= fifo_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) fifo_mem[wr_ptr] <= d_dout[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_byte  <= '0;
            uart_tx  <= 1'b1;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= bit_nxt;
            uart_tx  <= tx_nxt;
            if (fifo_pop) tx_byte <= fifo_mem[rd_ptr];
        end
    end

    // Next-state logic; uart_tx is registered from the level of the state being entered
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_idx;
        fifo_pop  = 1'b0;
        tx_nxt    = 1'b1;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = ST_START;
                    baud_nxt  = '0;
                end
            end
            ST_START: begin
                baud_nxt = baud_cnt + BAUD_W'(1);
                if (baud_done) begin
                    state_nxt = ST_DATA;
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                end
            end
            ST_DATA: begin
                baud_nxt = baud_cnt + BAUD_W'(1);
                if (baud_done) begin
                    baud_nxt = '0;
                    if (bit_idx == 3'd7) state_nxt = ST_STOP;
                    else                 bit_nxt   = bit_idx + 3'd1;
                end
            end
            ST_STOP: begin
                baud_nxt = baud_cnt + BAUD_W'(1);
                if (baud_done) begin
                    baud_nxt = '0;
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        state_nxt = ST_START;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        case (state_nxt)
            ST_START: tx_nxt = 1'b0;
            ST_DATA:  tx_nxt = tx_byte[bit_nxt];
            default:  tx_nxt = 1'b1;
        endcase
    end
`else
    logic [31:0] cfg_unused;

    assign cfg_unused  = 32'(CLKS_PER_BIT) ^ 32'(FIFO_DEPTH);
    assign uart_status = '0;
    assign uart_tx     = 1'b1;
`endif

endmodule

// File: tb/tb_risc16b_io.sv
// tb_risc16b_io: randomized register-access checks against a behavioural model, plus UART frame checks.
module tb_risc16b_io;
    localparam int unsigned CLKS  = 4;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] d_addr = '0;
    logic        d_oe = 1'b0;
    logic [15:0] d_dout = '0;
    logic [1:0]  d_we = '0;
    logic        io_sel;
    logic [15:0] io_din;
    logic [15:0] led;
    logic        uart_tx;

    risc16b_io #(.CLKS_PER_BIT(CLKS), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .d_addr(d_addr), .d_oe(d_oe), .d_dout(d_dout),
        .d_we(d_we), .io_sel(io_sel), .io_din(io_din), .led(led), .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] m_led = '0;
    logic [15:0] m_shadow = '0;
    logic [31:0] m_cnt = '0;
    bit          capture = 1'b0;
    logic        tx_log [$];
    logic        exp_q [$];

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic oe, input logic [1:0] we, input logic [15:0] dat);
        d_addr = a;
        d_oe   = oe;
        d_we   = we;
        d_dout = dat;
    endtask

    // One clock: the model applies the register rules to whatever is on the bus at the edge
    task automatic step();
        bit clear;
        @(posedge clk);
        if (!rst) begin
            clear = 1'b0;
            if (d_addr[15:8] == 8'h7f) begin
                case (d_addr[7:1])
                    7'd0: begin
                        if (d_we[0]) m_led[15:8] = d_dout[15:8];
                        if (d_we[1]) m_led[7:0]  = d_dout[7:0];
                    end
                    7'd1: begin
                        if (d_oe) m_shadow = m_cnt[31:16];
                        clear = (d_we != 2'b00);
                    end
                    default: ;
                endcase
            end
            m_cnt = clear ? 32'd0 : m_cnt + 32'd1;
        end
        @(negedge clk);
        if (capture) tx_log.push_back(uart_tx);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Expected line levels for one 8N1 frame, CLKS samples per bit
    task automatic add_frame(input logic [7:0] b);
        for (int s = 0; s < 10; s++) begin
            logic bv;
            bv = (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : b[s-1];
            for (int c = 0; c < int'(CLKS); c++) exp_q.push_back(bv);
        end
    endtask

    // Frames must begin at capture index 1 (one edge after the push) and be followed by idle
    task automatic check_frames(input string tag);
        logic obs;
        check1({tag, "_pre_idle"}, tx_log[0], 1'b1);
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = (i + 1 < tx_log.size()) ? tx_log[i+1] : 1'bx;
            check1(tag, obs, exp_q[i]);
        end
        obs = (exp_q.size() + 1 < tx_log.size()) ? tx_log[exp_q.size()+1] : 1'bx;
        check1({tag, "_post_idle"}, obs, 1'b1);
    endtask

    initial begin
        logic [7:0]  hi;
        logic [6:0]  ridx;
        logic [1:0]  rwe;
        logic [15:0] rdat;
        int          op;

        // Reset state, including immediate effect of async reset
        #1;
        check1("rst_uart_tx", uart_tx, 1'b1);
        check16("rst_led", led, 16'h0000);
        steps(2);
        rst = 1'b0;
        drive(16'h7f02, 1'b1, 2'b00, 16'h0000);
        #1 check16("rst_cnt_lo", io_din, 16'h0000);
        check1("rst_io_sel", io_sel, 1'b1);
        drive(16'h7f04, 1'b1, 2'b00, 16'h0000);
        #1 check16("rst_cnt_hi", io_din, 16'h0000);
        drive(16'h7f06, 1'b1, 2'b00, 16'h0000);
        #1 check16("rst_uart_status", io_din, 16'h0000);
        drive(16'h7f00, 1'b0, 2'b00, 16'h0000);
        #1 check16("no_oe_zero", io_din, 16'h0000);

        // Byte-lane LED writes
        drive(16'h7f00, 1'b0, 2'b01, 16'hA55A);
        step();
        check16("led_hi_lane", led, 16'hA500);
        drive(16'h7f01, 1'b0, 2'b10, 16'h1234);
        step();
        check16("led_lo_lane", led, 16'hA534);
        drive(16'h7f00, 1'b1, 2'b00, 16'h0000);
        #1 check16("led_read", io_din, 16'hA534);

        // Coherent 32-bit counter read across a low-half wrap
        drive(16'h7f02, 1'b1, 2'b00, 16'h0000);
        force dut.cnt = 32'h0001FFFF;
        #1 check16("cnt_lo_forced", io_din, 16'hFFFF);
        @(posedge clk);
        @(negedge clk);
        release dut.cnt;
        drive(16'h7f04, 1'b1, 2'b00, 16'h0000);
        #1 check16("cnt_hi_shadow", io_din, 16'h0001);
        m_shadow = 16'h0001;
        drive(16'h7f02, 1'b0, 2'b11, 16'hFFFF);
        step();
        drive(16'h7f02, 1'b1, 2'b00, 16'h0000);
        #1 check16("cnt_cleared", io_din, m_cnt[15:0]);
        step();
        drive(16'h7f02, 1'b0, 2'b00, 16'h0000);
        steps(3);
        drive(16'h7f02, 1'b1, 2'b00, 16'h0000);
        #1 check16("cnt_counting", io_din, m_cnt[15:0]);
        step();

        // Randomized register traffic against the model
        for (int it = 0; it < 80; it++) begin
            op   = int'($urandom_range(0, 6));
            rwe  = 2'($urandom);
            rdat = 16'($urandom);
            case (op)
                0: begin
                    drive({8'h7f, 7'd0, 1'($urandom)}, 1'($urandom), rwe, rdat);
                    step();
                    check16("rand_led_write", led, m_led);
                end
                1: begin
                    drive({8'h7f, 7'd0, 1'($urandom)}, 1'b1, 2'b00, rdat);
                    #1 check16("rand_led_read", io_din, m_led);
                    step();
                end
                2: begin
                    drive({8'h7f, 7'd1, 1'($urandom)}, 1'b1, 2'b00, rdat);
                    #1 check16("rand_cnt_lo", io_din, m_cnt[15:0]);
                    step();
                end
                3: begin
                    drive({8'h7f, 7'd2, 1'($urandom)}, 1'b1, rwe, rdat);
                    #1 check16("rand_cnt_hi", io_din, m_shadow);
                    step();
                end
                4: begin
                    ridx = 7'($urandom_range(4, 127));
                    drive({8'h7f, ridx, 1'($urandom)}, 1'b1, rwe, rdat);
                    #1 check16("rand_unmapped", io_din, 16'h0000);
                    step();
                    check16("rand_unmapped_led", led, m_led);
                end
                5: begin
                    hi = 8'($urandom);
                    if (hi == 8'h7f) hi = 8'h80;
                    drive({hi, 8'($urandom)}, 1'b1, rwe, rdat);
                    #1 check1("rand_not_io_sel", io_sel, 1'b0);
                    check16("rand_not_io_din", io_din, 16'h0000);
                    step();
                    check16("rand_not_io_led", led, m_led);
                end
                default: begin
                    drive({8'h7f, 7'd1, 1'($urandom)}, 1'b0, (rwe == 2'b00) ? 2'b11 : rwe, rdat);
                    step();
                end
            endcase
            drive(16'h0000, 1'b0, 2'b00, 16'h0000);
            steps(int'($urandom_range(0, 3)));
        end

`ifdef RISC16B_IO_UART_EN
        // d_we[0] alone does not push
        drive(16'h7f06, 1'b0, 2'b01, 16'h00FF);
        step();
        drive(16'h7f06, 1'b1, 2'b00, 16'h0000);
        #1 check16("uart_lane0_ignored", io_din, 16'h0000);

        // Single frame
        tx_log.delete();
        exp_q.delete();
        capture = 1'b1;
        drive(16'h7f06, 1'b0, 2'b10, 16'hC341);
        add_frame(8'h41);
        step();
        drive(16'h7f06, 1'b1, 2'b00, 16'h0000);
        #1 check16("uart_busy_queued", io_din, 16'h0001);
        steps(20);
        check16("uart_busy_mid", io_din, 16'h0001);
        steps(25);
        check16("uart_idle_after", io_din, 16'h0000);
        check_frames("frame_41");
        capture = 1'b0;

        // Overfill: DEPTH+1 accepted, the rest dropped, frames back-to-back
        tx_log.delete();
        exp_q.delete();
        capture = 1'b1;
        for (int k = 0; k < int'(DEPTH) + 2; k++) begin
            rdat = 16'($urandom);
            if (k <= int'(DEPTH)) add_frame(rdat[7:0]);
            drive(16'h7f06, 1'b0, 2'b10, rdat);
            step();
        end
        drive(16'h7f06, 1'b1, 2'b00, 16'h0000);
        #1 check16("uart_full_status", io_din, 16'h0003);
        steps(40 * (int'(DEPTH) + 1) + 5);
        check16("uart_drained", io_din, 16'h0000);
        check_frames("frame_burst");
        capture = 1'b0;

        // Reset in the middle of a frame's data bits
        drive(16'h7f06, 1'b0, 2'b10, 16'h0000);
        step();
        drive(16'h7f06, 1'b0, 2'b10, 16'h00A7);
        step();
        drive(16'h7f06, 1'b0, 2'b10, 16'h005C);
        step();
        drive(16'h0000, 1'b0, 2'b00, 16'h0000);
        steps(6);
        check1("uart_in_data_low", uart_tx, 1'b0);
        rst = 1'b1;
        m_led = '0;
        m_cnt = '0;
        m_shadow = '0;
        #1 check1("uart_rst_immediate", uart_tx, 1'b1);
        drive(16'h7f06, 1'b1, 2'b00, 16'h0000);
        #1 check16("uart_rst_status", io_din, 16'h0000);
        step();
        rst = 1'b0;
        #1 check16("uart_post_rst_status", io_din, 16'h0000);
        check16("post_rst_led", led, 16'h0000);
        drive(16'h7f02, 1'b1, 2'b00, 16'h0000);
        #1 check16("post_rst_cnt", io_din, m_cnt[15:0]);
        drive(16'h0000, 1'b0, 2'b00, 16'h0000);
        tx_log.delete();
        capture = 1'b1;
        steps(50);
        for (int i = 0; i < tx_log.size(); i += 5) check1("post_rst_line_idle", tx_log[i], 1'b1);
        capture = 1'b0;
`else
        // UART absent: index 3 is inert and the line stays idle
        tx_log.delete();
        capture = 1'b1;
        drive(16'h7f06, 1'b0, 2'b11, 16'h0055);
        step();
        drive(16'h7f06, 1'b1, 2'b00, 16'h0000);
        #1 check16("no_uart_status", io_din, 16'h0000);
        check16("no_uart_led", led, m_led);
        drive(16'h0000, 1'b0, 2'b00, 16'h0000);
        steps(30);
        for (int i = 0; i < tx_log.size(); i += 3) check1("no_uart_line_idle", tx_log[i], 1'b1);
        capture = 1'b0;
        drive(16'h7f02, 1'b1, 2'b00, 16'h0000);
        #1 check16("no_uart_cnt", io_din, m_cnt[15:0]);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
